// File: rtl/frame_seq.sv
`timescale 1ns/1ps
// frame_seq: animation frame sequencer feeding the 7-segment frame decoders.
// A prescaler produces one tick every TICK_DIV cycles. Each tick (or a single
// step while paused) advances the 5-bit frame index using one of three
// playback modes: one-shot, loop or ping-pong.
module frame_seq #(
    parameter int TICK_DIV   = 25000000,
    parameter int LAST_FRAME = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       step,
    input  logic [1:0] mode,
    output logic [4:0] idx,
    output logic       busy,
    output logic       frame_strobe,
    output logic       done
);

    // Prescaler only needs to reach TICK_DIV-1, so clog2 bits never overflow.
    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [4:0]      LAST_IDX  = 5'(LAST_FRAME);

    // Playback modes as latched at start; code 3 falls through to loop.
    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_reg,  state_next;
    logic [4:0]    idx_reg,    idx_next;
    logic [PW-1:0] presc_reg,  presc_next;
    logic          dir_down_reg, dir_down_next;
    logic [1:0]    mode_reg,   mode_next;
    logic          busy_reg,   busy_next;
    logic          strobe_reg, strobe_next;
    logic          done_reg,   done_next;

    // Result of one advance from the current frame (used by both tick and step).
    logic [4:0]    adv_idx;
    logic          adv_dir_down;
    logic          adv_finish;
    logic          do_adv;

    // Advance rule: what the next frame would be if a tick/step happened now.
    always_comb begin
        adv_idx      = idx_reg;
        adv_dir_down = dir_down_reg;
        adv_finish   = 1'b0;
        case (mode_reg)
            MODE_ONESHOT: begin
                // Reaching the end does not move idx; it finishes playback instead.
                if (idx_reg == LAST_IDX) begin
                    adv_finish = 1'b1;
                end else begin
                    adv_idx = idx_reg + 5'd1;
                end
            end
            MODE_PINGPONG: begin
                // Endpoints are shown once: turn around and step immediately.
                if (!dir_down_reg) begin
                    if (idx_reg == LAST_IDX) begin
                        adv_dir_down = 1'b1;
                        adv_idx      = LAST_IDX - 5'd1;
                    end else begin
                        adv_idx = idx_reg + 5'd1;
                    end
                end else begin
                    if (idx_reg == 5'd0) begin
                        adv_dir_down = 1'b0;
                        adv_idx      = 5'd1;
                    end else begin
                        adv_idx = idx_reg - 5'd1;
                    end
                end
            end
            default: begin
                // Loop (mode 1 and the unused code 3).
                if (idx_reg == LAST_IDX) begin
                    adv_idx = 5'd0;
                end else begin
                    adv_idx = idx_reg + 5'd1;
                end
            end
        endcase
    end

    // Next-state and output logic; priority is stop > start > tick/step > pause.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        presc_next    = presc_reg;
        dir_down_next = dir_down_reg;
        mode_next     = mode_reg;
        strobe_next   = 1'b0;
        done_next     = 1'b0;
        do_adv        = 1'b0;

        if (stop) begin
            state_next = ST_IDLE;
            idx_next   = 5'd0;
            presc_next = '0;
        end else if (start) begin
            // Restart from frame 0; strobe only if the visible index moves.
            state_next    = ST_RUN;
            idx_next      = 5'd0;
            presc_next    = '0;
            dir_down_next = 1'b0;
            mode_next     = mode;
            strobe_next   = (idx_reg != 5'd0);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    idx_next   = 5'd0;
                    presc_next = '0;
                end
                ST_RUN: begin
                    if (presc_reg == PRESC_MAX) begin
                        presc_next = '0;
                        do_adv     = 1'b1;
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                    // A tick on the pause edge still happens (handled below).
                    if (pause) begin
                        state_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    // Prescaler stays frozen so resuming keeps the frame phase.
                    do_adv = step;
                    if (!pause) begin
                        state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Hold the last frame until start or stop.
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        if (do_adv) begin
            if (adv_finish) begin
                state_next = ST_DONE;
                done_next  = 1'b1;
            end else begin
                idx_next      = adv_idx;
                dir_down_next = adv_dir_down;
                strobe_next   = 1'b1;
            end
        end

        busy_next = (state_next == ST_RUN) || (state_next == ST_PAUSE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 5'd0;
            presc_reg    <= '0;
            dir_down_reg <= 1'b0;
            mode_reg     <= 2'd0;
            busy_reg     <= 1'b0;
            strobe_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            presc_reg    <= presc_next;
            dir_down_reg <= dir_down_next;
            mode_reg     <= mode_next;
            busy_reg     <= busy_next;
            strobe_reg   <= strobe_next;
            done_reg     <= done_next;
        end
    end

    assign idx          = idx_reg;
    assign busy         = busy_reg;
    assign frame_strobe = strobe_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_frame_seq.sv
`timescale 1ns/1ps
// Testbench for frame_seq: three instances with different rates/lengths share
// one stimulus stream. Directed tasks check the documented sequences; a random
// phase compares every cycle against a frame-count reference model.
module tb_frame_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       pause = 1'b0;
    logic       step  = 1'b0;
    logic [1:0] mode  = 2'd0;

    logic [4:0] idx_a, idx_b, idx_c;
    logic       busy_a, busy_b, busy_c;
    logic       strobe_a, strobe_b, strobe_c;
    logic       done_a, done_b, done_c;

    frame_seq #(.TICK_DIV(4), .LAST_FRAME(5)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .step(step), .mode(mode), .idx(idx_a), .busy(busy_a),
        .frame_strobe(strobe_a), .done(done_a));
    frame_seq #(.TICK_DIV(2), .LAST_FRAME(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .step(step), .mode(mode), .idx(idx_b), .busy(busy_b),
        .frame_strobe(strobe_b), .done(done_b));
    frame_seq #(.TICK_DIV(4), .LAST_FRAME(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .step(step), .mode(mode), .idx(idx_c), .busy(busy_c),
        .frame_strobe(strobe_c), .done(done_c));

    localparam int NI = 3;
    int td [NI] = '{4, 2, 4};
    int lf [NI] = '{5, 3, 3};

    logic [4:0] o_idx    [NI];
    logic       o_busy   [NI];
    logic       o_strobe [NI];
    logic       o_done   [NI];
    assign o_idx[0] = idx_a;    assign o_idx[1] = idx_b;    assign o_idx[2] = idx_c;
    assign o_busy[0] = busy_a;  assign o_busy[1] = busy_b;  assign o_busy[2] = busy_c;
    assign o_strobe[0] = strobe_a; assign o_strobe[1] = strobe_b; assign o_strobe[2] = strobe_c;
    assign o_done[0] = done_a;  assign o_done[1] = done_b;  assign o_done[2] = done_c;

    int vectors = 0;
    int errors  = 0;

    // Reference model: playback tracked as a count of advances since start;
    // the visible frame is derived from that count per mode.
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
    int m_st   [NI];
    int m_p    [NI];
    int m_cnt  [NI];
    int m_mode [NI];
    bit m_strobe [NI];
    bit m_done   [NI];

    function automatic int m_idx(input int k);
        if (m_mode[k] == 0)      return (m_p[k] > lf[k]) ? lf[k] : m_p[k];
        else if (m_mode[k] == 2) return (m_p[k] <= lf[k]) ? m_p[k] : 2 * lf[k] - m_p[k];
        else                     return m_p[k];
    endfunction

    task automatic model_advance(input int k);
        if (m_mode[k] == 0) begin
            if (m_p[k] == lf[k]) begin
                m_st[k] = S_DONE;
                m_done[k] = 1'b1;
            end else begin
                m_p[k] = m_p[k] + 1;
                m_strobe[k] = 1'b1;
            end
        end else if (m_mode[k] == 2) begin
            m_p[k] = (m_p[k] + 1) % (2 * lf[k]);
            m_strobe[k] = 1'b1;
        end else begin
            m_p[k] = (m_p[k] + 1) % (lf[k] + 1);
            m_strobe[k] = 1'b1;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            m_strobe[k] = 1'b0;
            m_done[k]   = 1'b0;
            if (!rst_n) begin
                m_st[k] = S_IDLE; m_p[k] = 0; m_cnt[k] = 0; m_mode[k] = 0;
            end else if (stop) begin
                m_st[k] = S_IDLE; m_p[k] = 0; m_cnt[k] = 0;
            end else if (start) begin
                m_strobe[k] = (m_idx(k) != 0);
                m_st[k] = S_RUN; m_p[k] = 0; m_cnt[k] = 0;
                m_mode[k] = (mode == 2'd3) ? 1 : int'(mode);
            end else if (m_st[k] == S_RUN) begin
                if (m_cnt[k] == td[k] - 1) begin
                    m_cnt[k] = 0;
                    model_advance(k);
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
                if (m_st[k] == S_RUN && pause) m_st[k] = S_PAUSE;
            end else if (m_st[k] == S_PAUSE) begin
                if (step) model_advance(k);
                if (m_st[k] == S_PAUSE && !pause) m_st[k] = S_RUN;
            end
        end
    endtask

    // One clock: model follows the inputs sampled at the edge; outputs read 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        vectors++;
        if (idx_a !== 5'd0 || idx_b !== 5'd0 || idx_c !== 5'd0) begin
            errors++; $display("FAIL reset_idx got=%0d/%0d/%0d exp=0", idx_a, idx_b, idx_c);
        end
        vectors++;
        if ({busy_a, busy_b, busy_c, strobe_a, strobe_b, strobe_c, done_a, done_b, done_c} !== 9'd0) begin
            errors++; $display("FAIL reset_flags got busy=%b%b%b strobe=%b%b%b done=%b%b%b exp=all 0",
                               busy_a, busy_b, busy_c, strobe_a, strobe_b, strobe_c, done_a, done_b, done_c);
        end
        rst_n = 1'b1;
        repeat (3) cyc();
        vectors++;
        if (idx_a !== 5'd0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL idle_hold got idx=%0d busy=%b exp idx=0 busy=0", idx_a, busy_a);
        end
        $display("test_reset done");
    endtask

    task automatic test_loop();
        int seq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        mode = 2'd1; start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (idx_a !== 5'(seq[i / 4]) || busy_a !== 1'b1) begin
                errors++; $display("FAIL loop_idx cyc=%0d got idx=%0d busy=%b exp idx=%0d busy=1", i, idx_a, busy_a, seq[i / 4]);
            end
            vectors++;
            if (strobe_a !== ((i % 4 == 0) && (i > 0))) begin
                errors++; $display("FAIL loop_strobe cyc=%0d got=%b exp=%b", i, strobe_a, (i % 4 == 0) && (i > 0));
            end
            cyc();
        end
        $display("test_loop done");
    endtask

    task automatic test_oneshot();
        mode = 2'd0; start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (idx_c !== 5'(i / 4) || busy_c !== 1'b1 || done_c !== 1'b0) begin
                errors++; $display("FAIL oneshot_run cyc=%0d got idx=%0d busy=%b done=%b exp idx=%0d busy=1 done=0",
                                   i, idx_c, busy_c, done_c, i / 4);
            end
            if (i > 0) begin
                vectors++;
                if (strobe_c !== (i % 4 == 0)) begin
                    errors++; $display("FAIL oneshot_strobe cyc=%0d got=%b exp=%b", i, strobe_c, i % 4 == 0);
                end
            end
            cyc();
        end
        vectors++;
        if (done_c !== 1'b1 || busy_c !== 1'b0 || idx_c !== 5'd3 || strobe_c !== 1'b0) begin
            errors++; $display("FAIL oneshot_done got done=%b busy=%b idx=%0d strobe=%b exp done=1 busy=0 idx=3 strobe=0",
                               done_c, busy_c, idx_c, strobe_c);
        end
        cyc(); cyc();
        vectors++;
        if (done_c !== 1'b0 || idx_c !== 5'd3 || busy_c !== 1'b0) begin
            errors++; $display("FAIL oneshot_hold got done=%b idx=%0d busy=%b exp done=0 idx=3 busy=0", done_c, idx_c, busy_c);
        end
        start = 1'b1; cyc(); start = 1'b0;
        vectors++;
        if (idx_c !== 5'd0 || busy_c !== 1'b1 || strobe_c !== 1'b1) begin
            errors++; $display("FAIL oneshot_restart got idx=%0d busy=%b strobe=%b exp idx=0 busy=1 strobe=1", idx_c, busy_c, strobe_c);
        end
        $display("test_oneshot done");
    endtask

    task automatic test_pingpong();
        int seq [9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
        mode = 2'd2; start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            vectors++;
            if (idx_b !== 5'(seq[i / 2])) begin
                errors++; $display("FAIL pingpong_idx cyc=%0d got=%0d exp=%0d", i, idx_b, seq[i / 2]);
            end
            if (i > 0) begin
                vectors++;
                if (strobe_b !== (i % 2 == 0)) begin
                    errors++; $display("FAIL pingpong_strobe cyc=%0d got=%b exp=%b", i, strobe_b, i % 2 == 0);
                end
            end
            cyc();
        end
        $display("test_pingpong done");
    endtask

    task automatic test_pause_step();
        int n;
        bit found;
        mode = 2'd1; start = 1'b1; cyc(); start = 1'b0;
        repeat (9) cyc();
        vectors++;
        if (idx_a !== 5'd2) begin
            errors++; $display("FAIL pause_setup got idx=%0d exp=2", idx_a);
        end
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            vectors++;
            if (idx_a !== 5'd2 || strobe_a !== 1'b0 || busy_a !== 1'b1) begin
                errors++; $display("FAIL pause_hold cyc=%0d got idx=%0d strobe=%b busy=%b exp idx=2 strobe=0 busy=1",
                                   i, idx_a, strobe_a, busy_a);
            end
        end
        step = 1'b1; cyc(); step = 1'b0;
        vectors++;
        if (idx_a !== 5'd3 || strobe_a !== 1'b1) begin
            errors++; $display("FAIL pause_step got idx=%0d strobe=%b exp idx=3 strobe=1", idx_a, strobe_a);
        end
        cyc();
        vectors++;
        if (idx_a !== 5'd3 || strobe_a !== 1'b0) begin
            errors++; $display("FAIL pause_after_step got idx=%0d strobe=%b exp idx=3 strobe=0", idx_a, strobe_a);
        end
        pause = 1'b0;
        n = 0; found = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            cyc();
            if (strobe_a === 1'b1) begin found = 1'b1; n = i; end
        end
        vectors++;
        if (!found || n != 3 || idx_a !== 5'd4) begin
            errors++; $display("FAIL pause_resume got cycles=%0d idx=%0d exp cycles=3 idx=4", found ? n : -1, idx_a);
        end
        $display("test_pause_step done");
    endtask

    task automatic test_priority();
        mode = 2'd1; start = 1'b1; cyc(); start = 1'b0;
        repeat (5) cyc();
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        vectors++;
        if (idx_a !== 5'd0 || busy_a !== 1'b0 || strobe_a !== 1'b0) begin
            errors++; $display("FAIL prio_stop got idx=%0d busy=%b strobe=%b exp idx=0 busy=0 strobe=0", idx_a, busy_a, strobe_a);
        end
        repeat (6) cyc();
        vectors++;
        if (idx_a !== 5'd0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL prio_idle got idx=%0d busy=%b exp idx=0 busy=0", idx_a, busy_a);
        end
        start = 1'b1; cyc(); start = 1'b0;
        repeat (6) cyc();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        vectors++;
        if (idx_a !== 5'd0 || busy_a !== 1'b0 || strobe_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
            errors++; $display("FAIL mid_reset got idx=%0d busy=%b%b%b strobe=%b done=%b exp idx=0 busy=000 strobe=0 done=0",
                               idx_a, busy_a, busy_b, busy_c, strobe_a, done_a);
        end
        mode = 2'd1; start = 1'b1; cyc(); start = 1'b0; mode = 2'd0;
        repeat (24) cyc();
        vectors++;
        if (idx_a !== 5'd0 || busy_a !== 1'b1 || done_a !== 1'b0 || strobe_a !== 1'b1) begin
            errors++; $display("FAIL mode_ignored got idx=%0d busy=%b done=%b strobe=%b exp idx=0 busy=1 done=0 strobe=1",
                               idx_a, busy_a, done_a, strobe_a);
        end
        $display("test_priority done");
    endtask

    task automatic test_random();
        int exp_idx;
        bit exp_busy;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; step = 1'b0;
        cyc();
        for (int t = 0; t < 3000; t++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            start = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            step  = ($urandom_range(0, 5) == 0);
            mode  = 2'($urandom_range(0, 3));
            cyc();
            for (int k = 0; k < NI; k++) begin
                exp_idx  = m_idx(k);
                exp_busy = (m_st[k] == S_RUN) || (m_st[k] == S_PAUSE);
                vectors++;
                if (o_idx[k] !== 5'(exp_idx)) begin
                    errors++; $display("FAIL rand_idx t=%0d inst=%0d got=%0d exp=%0d", t, k, o_idx[k], exp_idx);
                end
                vectors++;
                if (o_busy[k] !== exp_busy) begin
                    errors++; $display("FAIL rand_busy t=%0d inst=%0d got=%b exp=%b", t, k, o_busy[k], exp_busy);
                end
                vectors++;
                if (o_strobe[k] !== m_strobe[k]) begin
                    errors++; $display("FAIL rand_strobe t=%0d inst=%0d got=%b exp=%b", t, k, o_strobe[k], m_strobe[k]);
                end
                vectors++;
                if (o_done[k] !== m_done[k]) begin
                    errors++; $display("FAIL rand_done t=%0d inst=%0d got=%b exp=%b", t, k, o_done[k], m_done[k]);
                end
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_loop();
        test_oneshot();
        test_pingpong();
        test_pause_step();
        test_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
